// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode/issue stage feeding the ALU. Decodes a subset of RV32I into a 3-bit
//   ALU op, two operands and memory/writeback/branch controls, and holds the
//   result in a single-entry pipeline register with valid/ready handshakes on
//   both sides and a synchronous flush.
//
// Parameters
//   CNT_W          width of the optional performance counters
//   ILLEGAL_AS_NOP 1: out_illegal tracks the held entry only
//                  0: out_illegal is sticky until flush or rst
//
// Optional feature macro: ID_EX_PERF_CNT_EN (adds out_issue_cnt/out_stall_cnt)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop held entry, block capture this cycle
//   in_valid / in_ready      upstream handshake
//   in_instr, in_pc          instruction word and its PC
//   in_rs1_data, in_rs2_data register file read data
//   out_valid / out_ready    downstream handshake
//   out_alu_op .. out_illegal registered decode results
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int unsigned CNT_W          = 32,
   parameter bit          ILLEGAL_AS_NOP = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_alu_op,
   output logic [31:0] out_operand1,
   output logic [31:0] out_operand2,
   output logic [31:0] out_store_data,
   output logic [31:0] out_imm,
   output logic [31:0] out_pc,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_branch,
   output logic        out_illegal
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] out_issue_cnt,
   output logic [CNT_W-1:0] out_stall_cnt
`endif
);

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_BEQ = 3'b111;

   typedef struct packed {
      logic [2:0]  alu_op;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] store_data;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        illegal;
   } entry_t;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd_field;
   logic [31:0] imm_i, imm_s, imm_b, imm_u;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   assign funct7   = in_instr[31:25];
   assign rd_field = in_instr[11:7];
   assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u    = {in_instr[31:12], 12'h000};

   entry_t raw;
   entry_t dec;
   entry_t entry_q, entry_d;
   logic   valid_q, valid_d;
   logic   capture;

   // Raw decode by opcode; raw.illegal flags anything outside the subset.
   always_comb begin
      raw         = '0;
      raw.pc      = in_pc;
      raw.illegal = 1'b0;
      case (opcode)
         OPC_R: begin
            raw.op1       = in_rs1_data;
            raw.op2       = in_rs2_data;
            raw.rd        = rd_field;
            raw.reg_write = 1'b1;
            case (funct3)
               3'b000: begin
                  if (funct7 == 7'b0000000) begin
                     raw.alu_op = ALU_ADD;
                  end else if (funct7 == 7'b0100000) begin
                     raw.alu_op = ALU_SUB;
                  end else begin
                     raw.illegal = 1'b1;
                  end
               end
               3'b111: begin raw.alu_op = ALU_AND; raw.illegal = (funct7 != 7'b0000000); end
               3'b110: begin raw.alu_op = ALU_OR;  raw.illegal = (funct7 != 7'b0000000); end
               3'b100: begin raw.alu_op = ALU_XOR; raw.illegal = (funct7 != 7'b0000000); end
               3'b010: begin raw.alu_op = ALU_SLT; raw.illegal = (funct7 != 7'b0000000); end
               default: raw.illegal = 1'b1;   // shifts, SLTU
            endcase
         end
         OPC_I: begin
            raw.op1       = in_rs1_data;
            raw.op2       = imm_i;
            raw.imm       = imm_i;
            raw.rd        = rd_field;
            raw.reg_write = 1'b1;
            case (funct3)
               3'b000:  raw.alu_op = ALU_ADD;
               3'b100:  raw.alu_op = ALU_XOR;
               3'b110:  raw.alu_op = ALU_OR;
               3'b111:  raw.alu_op = ALU_AND;
               3'b010:  raw.alu_op = ALU_SLT;
               default: raw.illegal = 1'b1;   // shifts, SLTIU
            endcase
         end
         OPC_LOAD: begin
            if (funct3 == 3'b010) begin
               raw.op1       = in_rs1_data;
               raw.op2       = imm_i;
               raw.imm       = imm_i;
               raw.rd        = rd_field;
               raw.reg_write = 1'b1;
               raw.mem_read  = 1'b1;
            end else begin
               raw.illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            if (funct3 == 3'b010) begin
               raw.op1        = in_rs1_data;
               raw.op2        = imm_s;
               raw.imm        = imm_s;
               raw.store_data = in_rs2_data;
               raw.mem_write  = 1'b1;
            end else begin
               raw.illegal = 1'b1;
            end
         end
         OPC_BRANCH: begin
            if (funct3 == 3'b000) begin
               raw.alu_op = ALU_BEQ;
               raw.op1    = in_rs1_data;
               raw.op2    = in_rs2_data;
               raw.imm    = imm_b;
               raw.branch = 1'b1;
            end else begin
               raw.illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            raw.op2       = imm_u;
            raw.imm       = imm_u;
            raw.rd        = rd_field;
            raw.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            raw.op1       = in_pc;
            raw.op2       = imm_u;
            raw.imm       = imm_u;
            raw.rd        = rd_field;
            raw.reg_write = 1'b1;
         end
         default: raw.illegal = 1'b1;
      endcase
   end

   // Illegal encodings collapse to an all-zero bubble; writes to x0 are dropped.
   always_comb begin
      dec = raw;
      if (raw.illegal) begin
         dec         = '0;
         dec.pc      = in_pc;
         dec.illegal = 1'b1;
      end else begin
         dec.reg_write = raw.reg_write & (raw.rd != 5'd0);
      end
   end

   assign in_ready = (~valid_q | out_ready) & ~flush;
   assign capture  = in_valid & in_ready;

   // Pipeline register next state: flush beats capture beats consume.
   always_comb begin
      entry_d = entry_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d         = 1'b0;
         entry_d.illegal = 1'b0;
      end else if (capture) begin
         entry_d = dec;
         valid_d = 1'b1;
         if (ILLEGAL_AS_NOP) begin
            entry_d.illegal = dec.illegal;
         end else begin
            entry_d.illegal = entry_q.illegal | dec.illegal;
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Pipeline register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         entry_q <= '0;
         valid_q <= 1'b0;
      end else begin
         entry_q <= entry_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_alu_op     = entry_q.alu_op;
   assign out_operand1   = entry_q.op1;
   assign out_operand2   = entry_q.op2;
   assign out_store_data = entry_q.store_data;
   assign out_imm        = entry_q.imm;
   assign out_pc         = entry_q.pc;
   assign out_rd         = entry_q.rd;
   assign out_reg_write  = entry_q.reg_write;
   assign out_mem_read   = entry_q.mem_read;
   assign out_mem_write  = entry_q.mem_write;
   assign out_branch     = entry_q.branch;
   assign out_illegal    = entry_q.illegal;

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Counter next state; both wrap naturally and ignore flush.
   always_comb begin
      if (valid_q && out_ready) begin
         issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end else begin
         issue_cnt_d = issue_cnt_q;
      end
      if (in_valid && !in_ready) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Counter registers, cleared by rst only.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_issue_cnt = issue_cnt_q;
   assign out_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] sd;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        ill;
   } dec_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      dec_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
   logic [2:0]  out_alu_op;
   logic [31:0] out_operand1, out_operand2, out_store_data, out_imm, out_pc;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] out_issue_cnt, out_stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic        m_valid;
   dec_t        m_ent;
   logic [31:0] m_pc;
   int unsigned m_issue, m_stall;

   vec_t vecs [16];

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
      .out_operand1(out_operand1), .out_operand2(out_operand2),
      .out_store_data(out_store_data), .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_branch(out_branch), .out_illegal(out_illegal)
`ifdef ID_EX_PERF_CNT_EN
      , .out_issue_cnt(out_issue_cnt), .out_stall_cnt(out_stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic dec_t mkd(input logic [2:0] op, input logic [31:0] op1, op2, sd, imm,
                                input logic [4:0] rd, input logic rw, mr, mw, br, ill);
      dec_t d;
      d = '{op, op1, op2, sd, imm, rd, rw, mr, mw, br, ill};
      return d;
   endfunction

   function automatic dec_t dut_ent();
      dec_t d;
      d = '{out_alu_op, out_operand1, out_operand2, out_store_data, out_imm, out_rd,
            out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal};
      return d;
   endfunction

   // Reference decoder: recognise the instruction, then fill fields from its meaning.
   function automatic dec_t ref_decode(input logic [31:0] instr, pc, a, b);
      dec_t        d;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        legal;
      int          ii, is, ib;
      logic [31:0] iu;
      opc = instr[6:0];
      f3  = instr[14:12];
      f7  = instr[31:25];
      ii  = int'($signed(instr[31:20]));
      is  = int'($signed({instr[31:25], instr[11:7]}));
      ib  = int'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      iu  = instr & 32'hFFFF_F000;
      d     = '0;
      legal = 1'b1;
      if (opc == 7'h33) begin
         d.op1 = a; d.op2 = b; d.rd = instr[11:7]; d.rw = 1'b1;
         if (f3 == 3'd0 && f7 == 7'h00)      d.op = 3'd0;
         else if (f3 == 3'd0 && f7 == 7'h20) d.op = 3'd1;
         else if (f3 == 3'd7 && f7 == 7'h00) d.op = 3'd2;
         else if (f3 == 3'd6 && f7 == 7'h00) d.op = 3'd3;
         else if (f3 == 3'd4 && f7 == 7'h00) d.op = 3'd4;
         else if (f3 == 3'd2 && f7 == 7'h00) d.op = 3'd5;
         else legal = 1'b0;
      end else if (opc == 7'h13) begin
         d.op1 = a; d.op2 = ii; d.imm = ii; d.rd = instr[11:7]; d.rw = 1'b1;
         if (f3 == 3'd0)      d.op = 3'd0;
         else if (f3 == 3'd4) d.op = 3'd4;
         else if (f3 == 3'd6) d.op = 3'd3;
         else if (f3 == 3'd7) d.op = 3'd2;
         else if (f3 == 3'd2) d.op = 3'd5;
         else legal = 1'b0;
      end else if (opc == 7'h03 && f3 == 3'd2) begin
         d.op1 = a; d.op2 = ii; d.imm = ii; d.rd = instr[11:7]; d.rw = 1'b1; d.mr = 1'b1;
      end else if (opc == 7'h23 && f3 == 3'd2) begin
         d.op1 = a; d.op2 = is; d.imm = is; d.sd = b; d.mw = 1'b1;
      end else if (opc == 7'h63 && f3 == 3'd0) begin
         d.op = 3'd7; d.op1 = a; d.op2 = b; d.imm = ib; d.br = 1'b1;
      end else if (opc == 7'h37) begin
         d.op2 = iu; d.imm = iu; d.rd = instr[11:7]; d.rw = 1'b1;
      end else if (opc == 7'h17) begin
         d.op1 = pc; d.op2 = iu; d.imm = iu; d.rd = instr[11:7]; d.rw = 1'b1;
      end else begin
         legal = 1'b0;
      end
      if (!legal) begin
         d     = '0;
         d.ill = 1'b1;
      end
      if (d.rd == 5'd0) d.rw = 1'b0;
      return d;
   endfunction

   // One clock cycle: drive, check in_ready, advance model, check registered outputs.
   task automatic cycle(input logic v, input logic [31:0] instr, pc, a, b,
                        input logic ordy, input logic fl, input logic r);
      logic exp_ready;
      in_valid = v; in_instr = instr; in_pc = pc; in_rs1_data = a; in_rs2_data = b;
      out_ready = ordy; flush = fl; rst = r;
      #1;
      exp_ready = (!m_valid || ordy) && !fl;
      check("in_ready", in_ready, exp_ready);
      if (r) begin
         m_valid = 1'b0; m_ent = '0; m_pc = 32'h0; m_issue = 0; m_stall = 0;
      end else begin
         if (m_valid && ordy) m_issue++;
         if (v && !exp_ready) m_stall++;
         if (fl) m_valid = 1'b0;
         else if (v && exp_ready) begin
            m_valid = 1'b1; m_ent = ref_decode(instr, pc, a, b); m_pc = pc;
         end else if (ordy) m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
         check("entry", dut_ent(), m_ent);
         check("out_pc", out_pc, m_pc);
      end
`ifdef ID_EX_PERF_CNT_EN
      check("issue_cnt", out_issue_cnt, m_issue);
      check("stall_cnt", out_stall_cnt, m_stall);
`endif
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] opc, f7;
      case ($urandom_range(0, 7))
         0: opc = 7'h33;
         1: opc = 7'h13;
         2: opc = 7'h03;
         3: opc = 7'h23;
         4: opc = 7'h63;
         5: opc = 7'h37;
         6: opc = 7'h17;
         default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0, 1: f7 = 7'h00;
         2: f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
   endfunction

   initial begin
      vecs[0]  = '{32'h002081B3, 32'h100, 32'd5,     32'd3,         mkd(3'd0, 32'd5, 32'd3, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      vecs[1]  = '{32'h402081B3, 32'h104, 32'd10,    32'd4,         mkd(3'd1, 32'd10, 32'd4, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      vecs[2]  = '{32'hFFF00293, 32'h108, 32'd0,     32'd9,         mkd(3'd0, 32'd0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      vecs[3]  = '{32'h00208463, 32'h10C, 32'd7,     32'd7,         mkd(3'd7, 32'd7, 32'd7, 32'h0, 32'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
      vecs[4]  = '{32'h0020A623, 32'h110, 32'h100,   32'hDEADBEEF,  mkd(3'd0, 32'h100, 32'd12, 32'hDEADBEEF, 32'd12, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
      vecs[5]  = '{32'h123453B7, 32'h114, 32'h55,    32'h66,        mkd(3'd0, 32'h0, 32'h12345000, 32'h0, 32'h12345000, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      vecs[6]  = '{32'h002091B3, 32'h118, 32'd1,     32'd2,         mkd(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
      vecs[7]  = '{32'h00208033, 32'h11C, 32'd1,     32'd2,         mkd(3'd0, 32'd1, 32'd2, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
      vecs[8]  = '{32'hFFC12203, 32'h120, 32'h200,   32'h0,         mkd(3'd0, 32'h200, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
      vecs[9]  = '{32'h00001097, 32'h1000, 32'h0,    32'h0,         mkd(3'd0, 32'h1000, 32'h1000, 32'h0, 32'h1000, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      vecs[10] = '{32'h0020B1B3, 32'h128, 32'd1,     32'd2,         mkd(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
      vecs[11] = '{32'h022081B3, 32'h12C, 32'd1,     32'd2,         mkd(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
      vecs[12] = '{32'h0F00C313, 32'h130, 32'hFF,    32'h0,         mkd(3'd4, 32'hFF, 32'hF0, 32'h0, 32'hF0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      vecs[13] = '{32'h0020A1B3, 32'h134, 32'd1,     32'd2,         mkd(3'd5, 32'd1, 32'd2, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      vecs[14] = '{32'h0020E1B3, 32'h138, 32'hF0,    32'h3C,        mkd(3'd3, 32'hF0, 32'h3C, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      vecs[15] = '{32'h0020F1B3, 32'h13C, 32'hF0,    32'h3C,        mkd(3'd2, 32'hF0, 32'h3C, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};

      m_valid = 1'b0; m_ent = '0; m_pc = 32'h0; m_issue = 0; m_stall = 0;

      // reset, then all outputs must be zero
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("reset_entry", dut_ent(), 160'h0);
      check("reset_pc", out_pc, 32'h0);

      // table vectors issued back-to-back with the consumer always ready
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 1'b1, 1'b0, 1'b0);
         check($sformatf("vec%0d", i), dut_ent(), vecs[i].exp);
         check($sformatf("vec%0d_pc", i), out_pc, vecs[i].pc);
      end
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // BEQ held for 3 cycles while upstream keeps offering another instruction
      cycle(1'b1, vecs[3].instr, vecs[3].pc, vecs[3].rs1, vecs[3].rs2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, vecs[0].instr, 32'h200, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
         check("hold_in_ready", in_ready, 1'b0);
         check("hold_entry", dut_ent(), vecs[3].exp);
      end
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // flush while holding, with a new instruction offered
      cycle(1'b1, vecs[0].instr, 32'h300, 32'd5, 32'd3, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, vecs[1].instr, 32'h304, 32'd9, 32'd9, 1'b0, 1'b1, 1'b0);
      check("flush_valid", out_valid, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("flush_not_captured", out_valid, 1'b0);

      // reset in the middle of a hold drops the entry completely
      cycle(1'b1, vecs[5].instr, 32'h400, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, vecs[0].instr, 32'h404, 32'd5, 32'd3, 1'b0, 1'b0, 1'b1);
      check("rst_hold_valid", out_valid, 1'b0);
      check("rst_hold_entry", dut_ent(), 160'h0);
      check("rst_hold_pc", out_pc, 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
               $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
